seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Controller that sequences the binary-to-BCD and BCD-to-segment datapath for a multiplexed, common-anode seven-segment display bank. A signed binary value is accepted on a single-cycle load strobe. The block converts it serially to BCD using shift-and-add-3, then applies leading-zero blanking, sign placement and overflow marking. It time-multiplexes the resulting digits onto one shared segment bus, one digit per scan slot, and sits between the numeric core logic and the board display pins.

## Interface
- `DIGITS`, default 4: number of physical digits, valid range 2..8.
- `WIDTH`, default 16: width of `value`, two's complement, valid range 4..32.
- `SCAN_DIV`, default 50000: clocks per digit slot, minimum 2.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: capture `value` when `busy` is 0; ignored when `busy` is 1.
- `value` in `WIDTH`: signed number to display.
- `busy` out 1: conversion in progress.
- `an` out `DIGITS`: active-low digit enables; `an[0]` is the least significant digit.
- `seg` out 8: active-low segments, {dp,g,f,e,d,c,b,a}.

## Operation
- The FSM has four states: `IDLE` → `ABS` → `CONV` → `FMT` → `IDLE`.
  - `IDLE`: when `load` is high, latch `value`, go to `ABS`, and set `busy` to 1.
  - `ABS`: latch the sign as `value[WIDTH-1]`. The magnitude is held as `WIDTH`-bit unsigned, so −2^(WIDTH−1) is handled exactly. Clear the BCD register.
  - `CONV`: process one magnitude bit per cycle, MSB first, for `WIDTH` cycles. Before each shift, add 3 to every BCD nibble ≥5.
  - `FMT`: build the `DIGITS`-nibble display register in one cycle, then return to `IDLE` and clear `busy`.
- The BCD register holds `NB = clog10(2^WIDTH − 1)` nibbles.
- Overflow condition, evaluated in `FMT`:
  - Positive value: any nibble at index ≥ `DIGITS` is nonzero.
  - Negative value: any nibble at index ≥ `DIGITS−1` is nonzero.
  - On overflow, every display digit is `Minus`.
- Formatting when there is no overflow:
  - Every zero nibble above the most significant nonzero nibble becomes `Empty`. Digit 0 is never blanked, so zero displays as "0".
  - If the value is negative, `Minus` goes in the position just above the most significant nonzero digit.
- The display register changes only in `FMT`, so scanning never shows a partial result.
- Scan counter:
  - `div_cnt` counts 0..`SCAN_DIV−1` continuously, independent of the FSM.
  - At the terminal count, `idx` advances by 1, wrapping from `DIGITS−1` to 0.
- Outputs are registered:
  - `an` is all ones except bit `idx`, which is 0.
  - `seg` is `BCD2ESC(disp[idx])`.
  - Both update together one cycle after `idx` changes.

## Timing
- All outputs take their reset values while `rst_n` is low:
  - `busy` = 0
  - `an` = all ones
  - `seg` = 8'hFF
  - `idx` = 0, `div_cnt` = 0
  - all display nibbles = `Empty`
  - FSM in `IDLE`
- Reset asserted in the middle of a conversion aborts it, and the display returns to all `Empty`.
- Load latency, counting the edge that samples `load` as edge 0:
  - `busy` is 1 after edge 0.
  - The display register updates at edge `WIDTH+2`, and `busy` is 0 after that same edge.
  - Total latency is 18 clocks for `WIDTH` = 16.
- Back-to-back loads:
  - `load` sampled in the same cycle that `FMT` completes is ignored, because `busy` is still 1.
  - `load` is accepted from the next cycle on.
- After release of reset, the first `an` low pulse appears one cycle after the first edge (`an[0]` low). Each digit is then active for `SCAN_DIV` clocks.
- A display-register update mid-slot takes effect on `seg` on the following cycle. No blanking interval is inserted.

## Structure
- Shared package `General1` supplies:
  - `uint4_t`, `uint8_t`
  - `Minus`, `Empty`
  - `BCD2ESC`, `clog10`, `clog2`
- `clog2` sizes `div_cnt` and `idx`.
- Add an FSM state enum `scan_state_t` to the same package.
- One sub-module is natural: `bcd_dabble`.
  - Parameters `WIDTH` and `NB`.
  - Ports: `start`, `bin`, `done`, `bcd`.
  - Owns the `CONV` shift and bit counter. The top level owns `ABS`, `FMT`, the display register and the scanner.

## Test plan
All scenarios use `DIGITS`=4, `WIDTH`=16, `SCAN_DIV`=4.
- Reset with no load → `busy`=0 and `an`=4'b1111 during reset. After reset, `an` walks 1110, 1101, 1011, 0111 every 4 clocks, with `seg`=8'hFF throughout.
- Load 1234 → `busy` high for 18 cycles, then digits 3..0 = 1,2,3,4. While `an`=1110, `seg`=8'b1001_1001; while `an`=0111, `seg`=8'b1111_1001.
- Load 7 → Empty, Empty, Empty, 7: `seg`=8'b1111_1000 on digit 0 and 8'hFF on digits 1–3. Load 0 → digit 0 shows 8'b1100_0000, others 8'hFF.
- Load −45 → Empty, Minus(8'b1011_1111), 4, 5. Load −999 → Minus, 9, 9, 9. Load −1000, 12345, and −32768 → all four digits 8'b1011_1111.
- Pulse `load` with 99 while `busy` → ignored, result of the first load stands. Pulse `load` on the `FMT` completion cycle → ignored. Pulse `load` one cycle later → accepted.
- Assert `rst_n` low at cycle 9 of a conversion → all outputs take reset values immediately, display all `Empty`. A new load of 5 then completes normally in 18 cycles.

Source files
------------

// File: rtl/seg7_scan_ctrl_pkg.sv
// rtl/seg7_scan_ctrl_pkg.sv - shared types, glyph codes and sizing helpers for the display controller
package General1;

    typedef logic [3:0] uint4_t;
    typedef logic [7:0] uint8_t;

    // Non-decimal nibble codes carried in the display register
    localparam uint4_t Minus = 4'hA;
    localparam uint4_t Empty = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ABS  = 2'd1,
        CONV = 2'd2,
        FMT  = 2'd3
    } scan_state_t;

    // Active-low {dp,g,f,e,d,c,b,a} for a common-anode digit
    function automatic uint8_t BCD2ESC(input uint4_t d);
        case (d)
            4'd0:    return 8'b1100_0000;
            4'd1:    return 8'b1111_1001;
            4'd2:    return 8'b1010_0100;
            4'd3:    return 8'b1011_0000;
            4'd4:    return 8'b1001_1001;
            4'd5:    return 8'b1001_0010;
            4'd6:    return 8'b1000_0010;
            4'd7:    return 8'b1111_1000;
            4'd8:    return 8'b1000_0000;
            4'd9:    return 8'b1001_0000;
            Minus:   return 8'b1011_1111;
            default: return 8'b1111_1111;
        endcase
    endfunction

    // Decimal digits needed to print x (at least one)
    function automatic int clog10(input longint unsigned x);
        longint unsigned p;
        int n;
        p = 1;
        n = 0;
        while (p <= x) begin
            p = p * 10;
            n = n + 1;
        end
        return (n == 0) ? 1 : n;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - load handshake and display pin bundle
interface seg7_scan_ctrl_if #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 16
);
    logic              load;
    logic [WIDTH-1:0]  value;
    logic              busy;
    logic [DIGITS-1:0] an;
    logic [7:0]        seg;

    modport master (output load, value, input busy, an, seg);
    modport slave  (input load, value, output busy, an, seg);
endinterface

// File: rtl/seg7_scan_ctrl_bcd_dabble.sv
// rtl/seg7_scan_ctrl_bcd_dabble.sv - serial shift-and-add-3 binary to BCD converter
module bcd_dabble
    import General1::*;
#(
    parameter int WIDTH = 16,
    parameter int NB    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  bin,
    output logic              done,
    output logic [4*NB-1:0]   bcd
);
    localparam int CW = clog2(WIDTH);

    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;
    logic             run;
    logic [4*NB-1:0]  adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // High during the cycle whose edge shifts in the last magnitude bit
    assign done = run && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh  <= '0;
            cnt <= '0;
            run <= 1'b0;
            bcd <= '0;
        end else if (start) begin
            sh  <= bin;
            cnt <= '0;
            run <= 1'b1;
            bcd <= '0;
        end else if (run) begin
            bcd <= (adj << 1) | {{(4*NB-1){1'b0}}, sh[WIDTH-1]};
            sh  <= sh << 1;
            cnt <= cnt + 1'b1;
            if (done) run <= 1'b0;
        end
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - signed value to multiplexed seven-segment display controller
module seg7_scan_ctrl
    import General1::*;
#(
    parameter int DIGITS   = 4,
    parameter int WIDTH    = 16,
    parameter int SCAN_DIV = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    seg7_scan_ctrl_if.slave bus
);
    localparam int NB = clog10((64'd1 << WIDTH) - 64'd1);
    localparam int DW = clog2(SCAN_DIV);
    localparam int IW = clog2(DIGITS);
    localparam int PW = NB + DIGITS;

    scan_state_t              state_q, state_d;
    logic [WIDTH-1:0]         val_q, mag;
    logic                     neg_q;
    logic                     dab_start, conv_done;
    logic [4*NB-1:0]          bcd;
    logic [4*PW-1:0]          bcd_pad;
    uint4_t [DIGITS-1:0]      disp_q, disp_d;
    logic                     ovf;
    int                       msd;
    logic [DW-1:0]            div_cnt;
    logic [IW-1:0]            idx;
    logic [DIGITS-1:0]        an_q;
    uint8_t                   seg_q;

    // Unsigned magnitude keeps the most negative value exact
    assign mag       = val_q[WIDTH-1] ? (~val_q) + WIDTH'(1) : val_q;
    assign dab_start = (state_q == ABS);
    assign bcd_pad   = {{(4*DIGITS){1'b0}}, bcd};

    bcd_dabble #(.WIDTH(WIDTH), .NB(NB)) u_dabble (
        .clk   (clk),
        .rst_n (rst_n),
        .start (dab_start),
        .bin   (mag),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.load) state_d = ABS;
            ABS:     state_d = CONV;
            CONV:    if (conv_done) state_d = FMT;
            FMT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        disp_d = {DIGITS{Empty}};
        ovf    = 1'b0;
        msd    = 0;
        for (int i = 0; i < NB; i++) begin
            if (bcd[4*i +: 4] != 4'd0 && (i >= DIGITS || (neg_q && i >= DIGITS - 1)))
                ovf = 1'b1;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_pad[4*i +: 4] != 4'd0) msd = i;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf)                         disp_d[i] = Minus;
            else if (i <= msd)               disp_d[i] = bcd_pad[4*i +: 4];
            else if (neg_q && i == msd + 1)  disp_d[i] = Minus;
            else                             disp_d[i] = Empty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            val_q   <= '0;
            neg_q   <= 1'b0;
            disp_q  <= {DIGITS{Empty}};
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.load) val_q <= bus.value;
            if (state_q == ABS)              neg_q <= val_q[WIDTH-1];
            if (state_q == FMT)              disp_q <= disp_d;
        end
    end

    assign bus.busy = (state_q != IDLE);

    // Scanner free-runs regardless of conversion activity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
            an_q    <= '1;
            seg_q   <= 8'hFF;
        end else begin
            if (div_cnt == DW'(SCAN_DIV - 1)) begin
                div_cnt <= '0;
                idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            an_q  <= ~(DIGITS'(1) << idx);
            seg_q <= BCD2ESC(disp_q[idx]);
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;
    localparam logic [7:0] S0 = 8'b1100_0000;
    localparam logic [7:0] S1 = 8'b1111_1001;
    localparam logic [7:0] S2 = 8'b1010_0100;
    localparam logic [7:0] S3 = 8'b1011_0000;
    localparam logic [7:0] S4 = 8'b1001_1001;
    localparam logic [7:0] S5 = 8'b1001_0010;
    localparam logic [7:0] S7 = 8'b1111_1000;
    localparam logic [7:0] S9 = 8'b1001_0000;
    localparam logic [7:0] SM = 8'b1011_1111;
    localparam logic [7:0] SE = 8'hFF;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    seg7_scan_ctrl_if #(.DIGITS(4), .WIDTH(16)) bus ();

    seg7_scan_ctrl #(.DIGITS(4), .WIDTH(16), .SCAN_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic do_load(input logic [15:0] v, output int cyc);
        bus.value = v;
        bus.load  = 1'b1;
        @(posedge clk); #1;
        bus.load  = 1'b0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic capture(output logic [3:0][7:0] s);
        s = 'x;
        repeat (16) begin
            @(posedge clk); #1;
            case (bus.an)
                4'b1110: s[0] = bus.seg;
                4'b1101: s[1] = bus.seg;
                4'b1011: s[2] = bus.seg;
                4'b0111: s[3] = bus.seg;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++;
        if (bus.an !== 4'b1111) begin fails++; $display("FAIL reset_an: got %b expected 1111", bus.an); end
        tests++;
        if (bus.seg !== SE) begin fails++; $display("FAIL reset_seg: got %h expected ff", bus.seg); end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            exp_an = 4'b1111 ^ (4'b0001 << (k / 4));
            tests++;
            if ({bus.an, bus.seg} !== {exp_an, SE}) begin
                fails++;
                $display("FAIL scan_walk[%0d]: got an=%b seg=%h expected an=%b seg=ff", k, bus.an, bus.seg, exp_an);
            end
        end
    endtask

    task automatic test_load_value(input string name, input logic [15:0] v, input logic [3:0][7:0] exp);
        int cyc;
        logic [3:0][7:0] s;
        do_load(v, cyc);
        tests++;
        if (cyc !== 18) begin fails++; $display("FAIL %s_latency: got %0d expected 18", name, cyc); end
        capture(s);
        tests++;
        if (s !== exp) begin fails++; $display("FAIL %s_digits: got %h expected %h", name, s, exp); end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        logic [3:0][7:0] s;
        bus.value = 16'd1234;
        bus.load  = 1'b1;
        @(posedge clk); #1;
        bus.load  = 1'b0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 5) begin bus.value = 16'd99; bus.load = 1'b1; end
            else bus.load = 1'b0;
        end
        tests++;
        if (cyc !== 18) begin fails++; $display("FAIL busy_ignore_latency: got %0d expected 18", cyc); end
        capture(s);
        tests++;
        if (s !== {S1, S2, S3, S4}) begin fails++; $display("FAIL busy_ignore_digits: got %h expected %h", s, {S1, S2, S3, S4}); end
    endtask

    task automatic test_fmt_edge();
        int cyc;
        logic [3:0][7:0] s;
        bus.value = 16'd7;
        bus.load  = 1'b1;
        @(posedge clk); #1;
        bus.load  = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        tests++;
        if (bus.busy !== 1'b1) begin fails++; $display("FAIL fmt_busy: got %b expected 1", bus.busy); end
        bus.value = 16'd99;
        bus.load  = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL fmt_load_ignored: got busy=%b expected 0", bus.busy); end
        bus.value = 16'd5;
        @(posedge clk); #1;
        bus.load  = 1'b0;
        tests++;
        if (bus.busy !== 1'b1) begin fails++; $display("FAIL next_load_accepted: got busy=%b expected 1", bus.busy); end
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests++;
        if (cyc !== 18) begin fails++; $display("FAIL next_load_latency: got %0d expected 18", cyc); end
        capture(s);
        tests++;
        if (s !== {SE, SE, SE, S5}) begin fails++; $display("FAIL next_load_digits: got %h expected %h", s, {SE, SE, SE, S5}); end
    endtask

    task automatic test_reset_mid();
        logic [3:0][7:0] s;
        bus.value = 16'd4321;
        bus.load  = 1'b1;
        @(posedge clk); #1;
        bus.load  = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.busy, bus.an, bus.seg} !== {1'b0, 4'b1111, SE}) begin
            fails++;
            $display("FAIL mid_reset_outputs: got busy=%b an=%b seg=%h expected 0 1111 ff", bus.busy, bus.an, bus.seg);
        end
        @(negedge clk) rst_n = 1'b1;
        capture(s);
        tests++;
        if (s !== {SE, SE, SE, SE}) begin fails++; $display("FAIL mid_reset_blank: got %h expected ffffffff", s); end
        test_load_value("after_reset_5", 16'd5, {SE, SE, SE, S5});
    endtask

    initial begin
        bus.load  = 1'b0;
        bus.value = '0;
        test_reset();
        test_load_value("v1234",   16'd1234,   {S1, S2, S3, S4});
        test_load_value("v7",      16'd7,      {SE, SE, SE, S7});
        test_load_value("v0",      16'd0,      {SE, SE, SE, S0});
        test_load_value("v9999",   16'd9999,   {S9, S9, S9, S9});
        test_load_value("vm45",    -16'd45,    {SE, SM, S4, S5});
        test_load_value("vm999",   -16'd999,   {SM, S9, S9, S9});
        test_load_value("vm1000",  -16'd1000,  {SM, SM, SM, SM});
        test_load_value("v12345",  16'd12345,  {SM, SM, SM, SM});
        test_load_value("vm32768", 16'h8000,   {SM, SM, SM, SM});
        test_busy_ignore();
        test_fmt_edge();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
